// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch queue: issues word fetches, buffers {pc, instr} pairs, flushes on redirect.
// Optional performance counters are enabled by defining IFQ_PERF_EN.
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
`ifdef IFQ_PERF_EN
  output logic [31:0] if_instr,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_flushed
`else
  output logic [31:0] if_instr
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pcMem    [DEPTH];
  logic [31:0]   r_instrMem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;
  logic [31:0]   r_fetchPc;
  logic [31:0]   r_respPc;

  logic        w_credit;
  logic        w_hs;
  logic        w_rsp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_target;

  // Outstanding requests reserve FIFO slots, so a response always finds room.
  assign w_credit = ((32'(r_count) + 32'(r_outst)) < 32'(DEPTH)) &&
                    (32'(r_outst) < 32'(MAX_OUTST));
  assign mem_req  = !reset && !redirect_valid && w_credit;
  assign mem_addr = r_fetchPc;
  assign w_hs     = mem_req && mem_gnt;
  assign w_rsp    = mem_rvalid && (r_outst != '0);
  assign w_drop   = w_rsp && (redirect_valid || (r_discard != '0));
  assign w_push   = w_rsp && !w_drop;
  assign w_pop    = (r_count != '0) && if_ready && !redirect_valid;
  assign w_target = {redirect_pc[31:2], 2'b00};

  assign if_valid = (r_count != '0);
  assign if_pc    = r_pcMem[r_rdPtr];
  assign if_instr = r_instrMem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pcMem[i]    <= '0;
        r_instrMem[i] <= NOP;
      end
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
      r_fetchPc <= RESET_PC;
      r_respPc  <= RESET_PC;
    end else begin
      r_outst <= r_outst + OW'(w_hs) - OW'(w_rsp);
      if (redirect_valid) begin
        // Every response still owed after this cycle belongs to the old path.
        r_discard <= r_outst - OW'(w_rsp);
        r_fetchPc <= w_target;
        r_respPc  <= w_target;
        r_count   <= '0;
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
      end else begin
        if (w_hs) r_fetchPc <= r_fetchPc + 32'd4;
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - OW'(1);
        if (w_push) begin
          r_pcMem[r_wrPtr]    <= r_respPc;
          r_instrMem[r_wrPtr] <= mem_rdata;
          r_wrPtr             <= r_wrPtr + AW'(1);
          r_respPc            <= r_respPc + 32'd4;
        end
        if (w_pop) r_rdPtr <= r_rdPtr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!mem_rvalid || (r_outst != '0))
        else $error("instr_fetch_queue: mem_rvalid with no outstanding request");
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perfDelivered;
  logic [31:0] r_perfFlushed;
  logic [31:0] w_flushInc;
  logic [32:0] w_flushSum;

  assign w_flushInc = (redirect_valid ? 32'(r_count) : 32'd0) + 32'(w_drop);
  assign w_flushSum = {1'b0, r_perfFlushed} + {1'b0, w_flushInc};

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perfDelivered <= '0;
      r_perfFlushed   <= '0;
    end else begin
      if (w_pop && (r_perfDelivered != 32'hFFFF_FFFF))
        r_perfDelivered <= r_perfDelivered + 32'd1;
      r_perfFlushed <= w_flushSum[32] ? 32'hFFFF_FFFF : w_flushSum[31:0];
    end
  end

  assign perf_delivered = r_perfDelivered;
  assign perf_flushed   = r_perfFlushed;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: table-driven cycle vectors plus hand-written redirect sequences.
// A small in-order memory model answers each granted request with rdata equal to its address.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_delivered;
  logic [31:0] perf_flushed;
`endif

  int vecCount = 0;
  int missCount = 0;
  logic [31:0] pending[$];

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          gnt;
    bit          rspEn;
    bit          rdy;
    bit          eReq;
    logic [31:0] eAddr;
    bit          eVal;
    logic [31:0] ePc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_queue #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
`ifdef IFQ_PERF_EN
    .if_instr(if_instr),
    .perf_delivered(perf_delivered),
    .perf_flushed(perf_flushed)
`else
    .if_instr(if_instr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: retire the answered request, queue the newly granted one.
  always @(posedge clk) begin
    if (reset) begin
      pending.delete();
    end else begin
      if (mem_rvalid) void'(pending.pop_front());
      if (mem_req && mem_gnt) pending.push_back(mem_addr);
    end
  end

  function automatic vec_t mk(bit rst, bit redir, logic [31:0] rpc, bit gnt, bit rspEn, bit rdy,
                              bit eReq, logic [31:0] eAddr, bit eVal, logic [31:0] ePc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rspEn = rspEn; v.rdy = rdy;
    v.eReq = eReq; v.eAddr = eAddr; v.eVal = eVal; v.ePc = ePc;
    return v;
  endfunction

  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit gnt,
                               input bit rspEn, input bit rdy);
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_gnt        = gnt;
    if_ready       = rdy;
    mem_rvalid     = rspEn && (pending.size() > 0);
    mem_rdata      = mem_rvalid ? pending[0] : 32'h0;
    #1;
  endtask

  task automatic checkOutput(input string name, input bit eReq, input logic [31:0] eAddr,
                             input bit eVal, input logic [31:0] ePc, input logic [31:0] eInstr,
                             input bit chkHead);
    bit bad;
    vecCount++;
    bad = (mem_req !== eReq) || (mem_addr !== eAddr) || (if_valid !== eVal);
    if (chkHead) bad = bad || (if_pc !== ePc) || (if_instr !== eInstr);
    if (bad) begin
      missCount++;
      $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, want req=%0b addr=%h valid=%0b pc=%h instr=%h",
               name, mem_req, mem_addr, if_valid, if_pc, if_instr, eReq, eAddr, eVal, ePc, eInstr);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
    if_ready       = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0013, 1'b1);
  endtask

  task automatic step(input string name, input bit redir, input logic [31:0] rpc, input bit gnt,
                      input bit rspEn, input bit rdy, input bit eReq, input logic [31:0] eAddr,
                      input bit eVal, input logic [31:0] ePc);
    applyStimulus(redir, rpc, gnt, rspEn, rdy);
    checkOutput(name, eReq, eAddr, eVal, ePc, ePc, eVal);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0; if_ready = 1'b0;

    // Streaming with a 1-cycle memory and decode always ready.
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h14, 1, 32'h0C));
    // Decode stalled: four requests fill the FIFO, then drain in order.
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h0C, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h10, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h10, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 32'h10, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h10, 1, 32'h04));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h14, 1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h18, 1, 32'h0C));
    // Grant withheld: address held, nothing enters the FIFO.
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h00, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h08, 1, 32'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) resetDut();
      applyStimulus(vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rspEn, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eVal,
                  vecs[i].ePc, vecs[i].ePc, vecs[i].eVal);
    end

    // Two late responses on the old path must be dropped after a misaligned redirect.
    resetDut();
    step("r1_redir0", 1, 32'h10, 1, 0, 1, 0, 32'h00, 0, 0);
    step("r1_req10",  0, 0, 1, 0, 1, 1, 32'h10, 0, 0);
    step("r1_req14",  0, 0, 1, 0, 1, 1, 32'h14, 0, 0);
    step("r1_full",   0, 0, 1, 0, 1, 0, 32'h18, 0, 0);
    step("r1_redir",  1, 32'h103, 1, 0, 1, 0, 32'h18, 0, 0);
    step("r1_drop0",  0, 0, 1, 1, 1, 0, 32'h100, 0, 0);
    step("r1_drop1",  0, 0, 1, 1, 1, 1, 32'h100, 0, 0);
    step("r1_fill",   0, 0, 1, 1, 1, 1, 32'h104, 0, 0);
    step("r1_head",   0, 0, 1, 1, 1, 1, 32'h108, 1, 32'h100);

    // Redirect coinciding with a response and a ready decode on a non-empty FIFO.
    resetDut();
    step("r2_c0",    0, 0, 1, 1, 0, 1, 32'h00, 0, 0);
    step("r2_c1",    0, 0, 1, 1, 0, 1, 32'h04, 0, 0);
    step("r2_c2",    0, 0, 1, 1, 0, 1, 32'h08, 1, 32'h00);
    step("r2_redir", 1, 32'h200, 1, 1, 1, 0, 32'h0C, 1, 32'h00);
    step("r2_empty", 0, 0, 1, 1, 1, 1, 32'h200, 0, 0);
    step("r2_fill",  0, 0, 1, 1, 1, 1, 32'h204, 0, 0);
    step("r2_head",  0, 0, 1, 1, 1, 1, 32'h208, 1, 32'h200);

`ifdef IFQ_PERF_EN
    // Three deliveries, then a redirect flushing two entries and one in-flight response.
    resetDut();
    step("p_c0", 0, 0, 1, 1, 1, 1, 32'h00, 0, 0);
    step("p_c1", 0, 0, 1, 1, 1, 1, 32'h04, 0, 0);
    step("p_c2", 0, 0, 1, 1, 1, 1, 32'h08, 1, 32'h00);
    step("p_c3", 0, 0, 1, 1, 1, 1, 32'h0C, 1, 32'h04);
    step("p_c4", 0, 0, 1, 1, 1, 1, 32'h10, 1, 32'h08);
    step("p_c5", 0, 0, 1, 1, 0, 1, 32'h14, 1, 32'h0C);
    step("p_redir", 1, 32'h300, 1, 0, 0, 0, 32'h18, 1, 32'h0C);
    step("p_drop", 0, 0, 1, 1, 0, 1, 32'h300, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    vecCount++;
    if (perf_delivered !== 32'd3 || perf_flushed !== 32'd3) begin
      missCount++;
      $display("[TB] FAIL perf: got delivered=%0d flushed=%0d, want delivered=3 flushed=3",
               perf_delivered, perf_flushed);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
